// File: rtl/bus_txn_ctrl.sv
// Snooping-bus transaction sequencer: grant -> broadcast -> snoop -> flush/fetch -> done.
// Optional snoop watchdog enabled by defining SNOOP_TIMEOUT_EN.
module bus_txn_ctrl #(
    parameter int NUM_CPUS       = 4,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CPUS-1:0]        gnt,
    input  logic [NUM_CPUS*2-1:0]      req_cmd,
    input  logic [NUM_CPUS*ADDR_W-1:0] req_addr,
    output logic                       busy,
    output logic                       bus_valid,
    output logic [1:0]                 bus_cmd,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [NUM_CPUS-1:0]        bus_src,
    input  logic [NUM_CPUS-1:0]        snoop_ack,
    input  logic [NUM_CPUS-1:0]        snoop_shared,
    input  logic [NUM_CPUS-1:0]        snoop_dirty,
    output logic                       mem_req,
    output logic                       mem_we,
    input  logic                       mem_ack,
    output logic [NUM_CPUS-1:0]        done,
    output logic                       resp_shared,
    output logic                       err
);

    typedef enum logic [2:0] {IDLE, BCAST, SNOOP, FLUSH, MEM, DONE} state_t;

    localparam logic [1:0] CMD_RD   = 2'd0;
    localparam logic [1:0] CMD_UPGR = 2'd2;
    localparam logic [1:0] CMD_RSVD = 2'd3;

    state_t              state;
    logic [NUM_CPUS-1:0] ack_seen, shared_acc, dirty_acc;
    logic [NUM_CPUS-1:0] ack_nxt, shared_nxt, dirty_nxt;
    logic                all_acked;

    logic [NUM_CPUS-1:0] sel_src;
    logic [1:0]          sel_cmd;
    logic [ADDR_W-1:0]   sel_addr;

    // Descending scan so the lowest set grant bit wins when gnt is not one-hot.
    always_comb begin
        sel_src  = '0;
        sel_cmd  = CMD_RD;
        sel_addr = '0;
        for (int i = NUM_CPUS - 1; i >= 0; i--) begin
            if (gnt[i]) begin
                sel_src    = '0;
                sel_src[i] = 1'b1;
                sel_cmd    = (req_cmd[i*2 +: 2] == CMD_RSVD) ? CMD_RD : req_cmd[i*2 +: 2];
                sel_addr   = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // The requester's own cache never answers its snoop: treat it as acked, ignore its flags.
    assign ack_nxt    = ack_seen | snoop_ack;
    assign shared_nxt = shared_acc | (snoop_shared & snoop_ack & ~bus_src);
    assign dirty_nxt  = dirty_acc  | (snoop_dirty  & snoop_ack & ~bus_src);
    assign all_acked  = &(ack_nxt | bus_src);

    assign busy = (state != IDLE);

`ifdef SNOOP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            err_q;
    assign err = err_q;
`else
    // Without the watchdog a completion can never carry an error.
    assign err = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus_valid   <= 1'b0;
            bus_cmd     <= '0;
            bus_addr    <= '0;
            bus_src     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            done        <= '0;
            resp_shared <= 1'b0;
            ack_seen    <= '0;
            shared_acc  <= '0;
            dirty_acc   <= '0;
`ifdef SNOOP_TIMEOUT_EN
            to_cnt      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            bus_valid   <= 1'b0;
            done        <= '0;
            resp_shared <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        bus_src   <= sel_src;
                        bus_cmd   <= sel_cmd;
                        bus_addr  <= sel_addr;
                        bus_valid <= 1'b1;
                        state     <= BCAST;
                    end
                end
                BCAST: begin
                    ack_seen   <= '0;
                    shared_acc <= '0;
                    dirty_acc  <= '0;
`ifdef SNOOP_TIMEOUT_EN
                    to_cnt     <= '0;
`endif
                    state      <= SNOOP;
                end
                SNOOP: begin
                    ack_seen   <= ack_nxt;
                    shared_acc <= shared_nxt;
                    dirty_acc  <= dirty_nxt;
                    if (all_acked) begin
                        if (|dirty_nxt) begin
                            mem_req <= 1'b1;
                            mem_we  <= 1'b1;
                            state   <= FLUSH;
                        end else if (bus_cmd == CMD_UPGR) begin
                            done        <= bus_src;
                            resp_shared <= |shared_nxt;
                            state       <= DONE;
                        end else begin
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            state   <= MEM;
                        end
                    end
`ifdef SNOOP_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        done  <= bus_src;
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                FLUSH: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        if (bus_cmd == CMD_UPGR) begin
                            mem_req     <= 1'b0;
                            done        <= bus_src;
                            resp_shared <= |shared_acc;
                            state       <= DONE;
                        end else begin
                            state <= MEM;
                        end
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        done        <= bus_src;
                        resp_shared <= |shared_acc;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_txn_ctrl.sv
// Directed bench for bus_txn_ctrl: reset, BusRd/BusRdX/BusUpgr flows, staggered acks, mid-txn reset.
module tb_bus_txn_ctrl;
    localparam int N = 4;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  gnt;
    logic [N*2-1:0] req_cmd;
    logic [N*AW-1:0] req_addr;
    logic          busy, bus_valid;
    logic [1:0]    bus_cmd;
    logic [AW-1:0] bus_addr;
    logic [N-1:0]  bus_src;
    logic [N-1:0]  snoop_ack, snoop_shared, snoop_dirty;
    logic          mem_req, mem_we, mem_ack;
    logic [N-1:0]  done;
    logic          resp_shared, err;

    int n_tests = 0;
    int n_fail  = 0;

    bus_txn_ctrl #(.NUM_CPUS(N), .ADDR_W(AW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .gnt(gnt), .req_cmd(req_cmd), .req_addr(req_addr),
        .busy(busy), .bus_valid(bus_valid), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .bus_src(bus_src), .snoop_ack(snoop_ack), .snoop_shared(snoop_shared),
        .snoop_dirty(snoop_dirty), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .done(done), .resp_shared(resp_shared), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snoop(input logic [N-1:0] a, input logic [N-1:0] s, input logic [N-1:0] d);
        snoop_ack = a; snoop_shared = s; snoop_dirty = d;
    endtask

    initial begin
        rst_n = 1'b0; gnt = '0; req_cmd = '0; req_addr = '0; mem_ack = 1'b0;
        snoop(4'b0000, 4'b0000, 4'b0000);
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_bus_addr", bus_addr, 0);
        tick(); rst_n = 1'b1;
        tick();

        // BusRd from CPU1 at 0x40, clean snoop, mem_ack three cycles after mem_req rises
        req_cmd[3:2] = 2'd0; req_addr[1*AW +: AW] = 32'h40; gnt = 4'b0010;
        tick();
        chk("rd_busy", busy, 1);
        chk("rd_bus_valid", bus_valid, 1);
        chk("rd_bus_cmd", bus_cmd, 0);
        chk("rd_bus_addr", bus_addr, 32'h40);
        chk("rd_bus_src", bus_src, 4'b0010);
        gnt = '0;
        tick();
        chk("rd_valid_one_pulse", bus_valid, 0);
        snoop(4'b1101, 4'b0000, 4'b0000);
        tick();
        snoop(4'b0000, 4'b0000, 4'b0000);
        chk("rd_mem_req", mem_req, 1);
        chk("rd_mem_we", mem_we, 0);
        tick(); tick(); tick();
        chk("rd_mem_req_held", mem_req, 1);
        chk("rd_no_early_done", done, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rd_done", done, 4'b0010);
        chk("rd_resp_shared", resp_shared, 0);
        chk("rd_mem_req_drop", mem_req, 0);
        tick();
        chk("rd_done_pulse", done, 0);
        chk("rd_busy_low", busy, 0);

        // BusRdX from CPU0; CPU2 holds the line dirty -> flush then fetch
        req_cmd[1:0] = 2'd1; req_addr[0 +: AW] = 32'h80; gnt = 4'b0001;
        tick();
        gnt = '0;
        chk("rdx_bus_cmd", bus_cmd, 1);
        chk("rdx_bus_src", bus_src, 4'b0001);
        tick();
        snoop(4'b0100, 4'b0100, 4'b0100);
        tick();
        snoop(4'b1010, 4'b0000, 4'b0000);
        chk("rdx_wait_acks", mem_req, 0);
        tick();
        snoop(4'b0000, 4'b0000, 4'b0000);
        chk("rdx_flush_req", mem_req, 1);
        chk("rdx_flush_we", mem_we, 1);
        mem_ack = 1'b1;
        tick();
        chk("rdx_mem_req", mem_req, 1);
        chk("rdx_mem_we", mem_we, 0);
        chk("rdx_no_early_done", done, 0);
        tick();
        mem_ack = 1'b0;
        chk("rdx_done", done, 4'b0001);
        chk("rdx_resp_shared", resp_shared, 1);
        tick();
        chk("rdx_busy_low", busy, 0);

        // BusUpgr from CPU3, CPU0 shared, all acks in first SNOOP cycle: done at N+3
        req_cmd[7:6] = 2'd2; req_addr[3*AW +: AW] = 32'hC0; gnt = 4'b1000;
        tick();
        gnt = '0;
        chk("upg_bus_cmd", bus_cmd, 2);
        tick();
        snoop(4'b0111, 4'b0001, 4'b0000);
        chk("upg_no_done_n2", done, 0);
        tick();
        snoop(4'b0000, 4'b0000, 4'b0000);
        chk("upg_done_n3", done, 4'b1000);
        chk("upg_resp_shared", resp_shared, 1);
        chk("upg_no_mem_req", mem_req, 0);
        chk("upg_err", err, 0);
        tick();
        chk("upg_busy_low", busy, 0);

        // Staggered acks; gnt not one-hot (lowest bit CPU1 wins); ack during BCAST must be ignored
        req_cmd[3:2] = 2'd2; req_cmd[7:6] = 2'd1; req_addr[1*AW +: AW] = 32'h100;
        gnt = 4'b1010;
        tick();
        gnt = '0;
        chk("stg_bus_src", bus_src, 4'b0010);
        chk("stg_bus_cmd", bus_cmd, 2);
        snoop(4'b0100, 4'b0000, 4'b0000);
        tick(); snoop(4'b0001, 4'b0000, 4'b0000);
        tick(); snoop(4'b1000, 4'b0000, 4'b0000);
        chk("stg_busy_c2", busy, 1);
        tick(); snoop(4'b0001, 4'b0000, 4'b0000);
        chk("stg_no_done_c3", done, 0);
        tick(); snoop(4'b0000, 4'b0000, 4'b0000);
        chk("stg_no_done_c4", done, 0);
        tick(); snoop(4'b0100, 4'b0000, 4'b0000);
        chk("stg_no_done_c5", done, 0);
        chk("stg_busy_c5", busy, 1);
        tick(); snoop(4'b0000, 4'b0000, 4'b0000);
        chk("stg_done", done, 4'b0010);
        chk("stg_resp_shared", resp_shared, 0);
        chk("stg_no_mem_req", mem_req, 0);
        tick();

`ifdef SNOOP_TIMEOUT_EN
        // CPU2 never acks: err completion eight cycles after SNOOP entry
        req_cmd[1:0] = 2'd0; gnt = 4'b0001;
        tick(); gnt = '0;
        tick(); snoop(4'b1010, 4'b0000, 4'b0000);
        for (int k = 1; k < 8; k++) begin
            tick(); snoop(4'b0000, 4'b0000, 4'b0000);
            chk("to_no_done", done, 0);
            chk("to_no_mem_req", mem_req, 0);
        end
        tick();
        chk("to_done", done, 4'b0001);
        chk("to_err", err, 1);
        chk("to_resp_shared", resp_shared, 0);
        tick();
`endif

        // Reserved cmd 3 from CPU2 maps to BusRd; reset while in MEM abandons it
        req_cmd[5:4] = 2'd3; req_addr[2*AW +: AW] = 32'h1234; gnt = 4'b0100;
        tick();
        gnt = '0;
        chk("rsv_bus_cmd", bus_cmd, 0);
        tick();
        snoop(4'b1011, 4'b0000, 4'b0000);
        tick();
        snoop(4'b0000, 4'b0000, 4'b0000);
        chk("mid_mem_req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_bus_src", bus_src, 0);
        chk("mid_rst_bus_addr", bus_addr, 0);
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_no_done", done, 0);
            chk("post_rst_idle", busy, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bus_txn_ctrl.md
# bus_txn_ctrl

Snooping-bus transaction sequencer for the MESI cache system. Sits downstream of the round-robin bus arbiter: accepts the one-hot grant, latches the winning CPU's bus command, broadcasts it to all caches, collects snoop responses, sequences dirty-line flush and memory fetch, then returns completion to the requester. Drives the arbiter's busy input, so only one bus transaction is ever in flight.

## Interface
Parameters:
- NUM_CPUS, from types package (4): number of cache/CPU ports.
- ADDR_W, 32: line address width.
- TIMEOUT_CYCLES, 64: snoop watchdog limit; used only when SNOOP_TIMEOUT_EN is defined.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- gnt  in  NUM_CPUS  one-hot grant from the arbiter.
- req_cmd  in  NUM_CPUS*2  per-CPU command: 0 BusRd, 1 BusRdX, 2 BusUpgr, 3 reserved.
- req_addr  in  NUM_CPUS*ADDR_W  per-CPU line address.
- busy  out  1  transaction in flight; feeds every bit of the arbiter busy vector.
- bus_valid  out  1  one-cycle broadcast strobe.
- bus_cmd  out  2  latched command.
- bus_addr  out  ADDR_W  latched address.
- bus_src  out  NUM_CPUS  one-hot requester.
- snoop_ack  in  NUM_CPUS  per-cache snoop-complete pulse.
- snoop_shared  in  NUM_CPUS  cache holds line (valid with its ack).
- snoop_dirty  in  NUM_CPUS  cache holds line Modified (valid with its ack).
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = flush writeback, 0 = line fetch.
- mem_ack  in  1  memory completion pulse.
- done  out  NUM_CPUS  one-hot completion pulse to requester.
- resp_shared  out  1  valid with done: another cache held the line.
- err  out  1  completion carried a timeout error (valid with done).

## Operation
- States: IDLE, BCAST, SNOOP, FLUSH, MEM, DONE. busy = (state != IDLE).
- IDLE: if gnt != 0, latch src (lowest set bit if gnt not one-hot), cmd, addr; go to BCAST. Reserved cmd 3 is treated as BusRd.
- BCAST: bus_valid=1 for exactly one cycle; clear ack/shared/dirty accumulators; go to SNOOP.
- SNOOP: accumulate ack_seen |= snoop_ack, shared_acc |= snoop_shared & snoop_ack, dirty_acc likewise. Requester's own bit is masked (ack implied, shared/dirty ignored). When all non-requester acks seen (including acks arriving that same cycle): dirty_acc != 0 -> FLUSH; else BusUpgr -> DONE; else -> MEM.
- FLUSH: mem_req=1, mem_we=1 until mem_ack; then BusUpgr -> DONE, else -> MEM. (Owner supplies data on the bus; memory is updated.)
- MEM: mem_req=1, mem_we=0 until mem_ack; then DONE.
- DONE: done[src]=1, resp_shared=|shared_acc, one cycle; then IDLE.
- Acks arriving outside SNOOP are ignored. Duplicate acks in SNOOP are harmless.
- NUM_CPUS=1: SNOOP completes on first cycle (no other caches).

## Timing
- Reset (async, rst_n low): state IDLE; busy, bus_valid, mem_req, mem_we, done, resp_shared, err = 0; bus_cmd, bus_addr, bus_src = 0; accumulators cleared. Reset mid-transaction abandons it with no done.
- Grant sampled at edge N -> busy=1 and bus_valid=1 in cycle N+1; SNOOP from N+2.
- Minimum latency gnt -> done: BusUpgr with all acks in first SNOOP cycle: done in cycle N+3; BusRd with clean snoop and mem_ack in first MEM cycle: N+4.
- busy falls in the cycle after DONE; arbiter may grant in that same IDLE cycle (back-to-back, one idle cycle between done pulses minimum).
- mem_ack in same cycle mem_req first rises is accepted.
- All outputs registered or decoded from state only; no combinational path from inputs to busy.

## Configuration
- SNOOP_TIMEOUT_EN defined: counter starts at 0 on entry to SNOOP; if TIMEOUT_CYCLES cycles pass without all acks, go to DONE with err=1, resp_shared=0, no memory access. Counter width clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter; SNOOP waits indefinitely; err tied to 0.

## Test plan
- Reset: rst_n low mid-MEM -> all outputs 0 immediately, no done after release.
- BusRd from CPU1 at 0x40, no sharers, mem_ack after 3 cycles -> bus_valid one pulse with cmd 0/addr 0x40/src 4'b0010, mem_we=0, done=4'b0010, resp_shared=0.
- BusRdX from CPU0, CPU2 acks with dirty -> FLUSH (mem_we=1) then MEM (mem_we=0), done=4'b0001.
- BusUpgr from CPU3, CPU0 acks shared -> no mem_req, done=4'b1000, resp_shared=1, latency N+3.
- Staggered acks (CPU0 cycle 1, CPU2 cycle 5, CPU3 cycle 2), requester's own ack never sent -> SNOOP exits cycle after CPU2 ack; busy high throughout.
- SNOOP_TIMEOUT_EN, TIMEOUT_CYCLES=8, CPU2 never acks -> done with err=1 eight cycles after SNOOP entry, no mem_req.
